// File: rtl/plm_response_router.sv
// PLM return path: delays each kernel's grant tag by the PLM read latency, captures
// the read word, and steers it (or a write ack) into a per-consumer FWFT response FIFO.

module plm_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_push_wr,
  input  logic [W-1:0] i_push_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic         o_wr,
  output logic [W-1:0] o_data,
  output logic         o_overflow
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_rd, r_wr;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;
  logic            w_valid, w_pop, w_full, w_acc;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & i_ready;
  assign w_full  = (r_cnt == CNTW'(DEPTH));
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_acc   = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_acc) begin
        r_mem[r_wr] <= {i_push_wr, i_push_data};
        r_wr        <= f_inc(r_wr);
      end
      if (w_pop) r_rd <= f_inc(r_rd);
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CNTW'(1);
        2'b01:   r_cnt <= r_cnt - CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (i_push & ~w_acc) r_ovf <= 1'b1;
    end
  end

  assign o_valid    = w_valid;
  assign o_wr       = w_valid & r_mem[r_rd][W];
  assign o_data     = (w_valid & ~r_mem[r_rd][W]) ? r_mem[r_rd][W-1:0] : '0;
  assign o_overflow = r_ovf;
endmodule

module plm_response_router #(
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 2,
  parameter int NBANKS      = 1,
  parameter int NPORTS      = 1,
  parameter int PLM_LATENCY = 1,
  parameter int RESP_DEPTH  = 2,
  localparam int NKERNELS   = NBANKS * NPORTS,
  localparam int CW         = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NKERNELS-1:0]                    grant_valid,
  input  logic [NKERNELS-1:0]                    grant_wr,
  input  logic [NKERNELS-1:0][CW-1:0]            grant_consumer,
  input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   plm_outputs,
  output logic [NCONSUMERS-1:0]                  resp_valid,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data,
  output logic [NCONSUMERS-1:0]                  resp_wr,
  input  logic [NCONSUMERS-1:0]                  resp_ready,
  output logic [NCONSUMERS-1:0]                  overflow,
  output logic                                   collision
);
  typedef struct packed {
    logic          vld;
    logic          wr;
    logic [CW-1:0] con;
  } tag_t;

  tag_t [PLM_LATENCY-1:0][NKERNELS-1:0] r_tag;
  tag_t [NKERNELS-1:0]                  w_in, w_out;
  logic [NCONSUMERS-1:0]                w_push, w_push_wr;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] w_push_data;
  logic                                 w_coll;
  logic                                 r_collision;

  always_comb begin
    for (int k = 0; k < NKERNELS; k++)
      w_in[k] = '{vld: grant_valid[k], wr: grant_wr[k], con: grant_consumer[k]};
  end

  // Free-running tag delay line; stage PLM_LATENCY-1 lines up with plm_outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_in;
      for (int i = 1; i < PLM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_out = r_tag[PLM_LATENCY-1];

  // Lowest kernel wins a consumer; out-of-range consumer indices never match.
  always_comb begin
    w_push      = '0;
    w_push_wr   = '0;
    w_push_data = '0;
    w_coll      = 1'b0;
    for (int c = 0; c < NCONSUMERS; c++) begin
      for (int k = 0; k < NKERNELS; k++) begin
        if (w_out[k].vld && (w_out[k].con == CW'(c))) begin
          if (w_push[c]) begin
            w_coll = 1'b1;
          end else begin
            w_push[c]      = 1'b1;
            w_push_wr[c]   = w_out[k].wr;
            w_push_data[c] = w_out[k].wr ? '0 : plm_outputs[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_collision <= 1'b0;
    else if (w_coll) r_collision <= 1'b1;
  end

  assign collision = r_collision;

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_cons
    plm_resp_fifo #(.W(VALUE_WIDTH), .DEPTH(RESP_DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push[c]),
      .i_push_wr   (w_push_wr[c]),
      .i_push_data (w_push_data[c]),
      .i_ready     (resp_ready[c]),
      .o_valid     (resp_valid[c]),
      .o_wr        (resp_wr[c]),
      .o_data      (resp_data[c]),
      .o_overflow  (overflow[c])
    );
  end
endmodule

// File: tb/tb_plm_response_router.sv
// Bench for plm_response_router: directed scenarios plus random traffic checked
// against a queue-based reference of per-consumer response FIFOs.

module tb_plm_response_router;
  localparam int W  = 8;
  localparam int NC = 3;
  localparam int NK = 2;
  localparam int L  = 2;
  localparam int D  = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NK-1:0]         grant_valid, grant_wr;
  logic [NK-1:0][1:0]    grant_consumer;
  logic [NK-1:0][W-1:0]  plm_outputs;
  logic [NC-1:0]         resp_valid, resp_wr, resp_ready, overflow;
  logic [NC-1:0][W-1:0]  resp_data;
  logic                  collision;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [NK-1:0]      v;
    logic [NK-1:0]      w;
    logic [NK-1:0][1:0] c;
  } tag_t;

  logic [W:0]    mq [NC][$];
  tag_t          tq [$];
  logic [NC-1:0] m_ovf;
  logic          m_coll;

  plm_response_router #(
    .VALUE_WIDTH(W), .NCONSUMERS(NC), .NBANKS(NK), .NPORTS(1),
    .PLM_LATENCY(L), .RESP_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset),
    .grant_valid(grant_valid), .grant_wr(grant_wr),
    .grant_consumer(grant_consumer), .plm_outputs(plm_outputs),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_wr(resp_wr),
    .resp_ready(resp_ready), .overflow(overflow), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic model_clear;
    for (int c = 0; c < NC; c++) mq[c].delete();
    tq.delete();
    m_ovf  = '0;
    m_coll = 1'b0;
  endtask

  // Drive one cycle, advance the reference across its closing edge, land on the next negedge.
  task automatic cycle(input logic [NK-1:0] gv, input logic [NK-1:0] gw,
                       input logic [NK-1:0][1:0] gc, input logic [NK-1:0][W-1:0] po,
                       input logic [NC-1:0] rdy);
    tag_t t, tn;
    logic [NC-1:0] hit;
    int c;
    grant_valid = gv; grant_wr = gw; grant_consumer = gc;
    plm_outputs = po; resp_ready = rdy;
    for (int cc = 0; cc < NC; cc++)
      if (mq[cc].size() > 0 && rdy[cc]) void'(mq[cc].pop_front());
    hit = '0;
    if (tq.size() == L) begin
      t = tq.pop_front();
      for (int k = 0; k < NK; k++) begin
        if (t.v[k] && int'(t.c[k]) < NC) begin
          c = int'(t.c[k]);
          if (hit[c]) m_coll = 1'b1;
          else begin
            hit[c] = 1'b1;
            if (mq[c].size() < D) mq[c].push_back({t.w[k], t.w[k] ? 8'h00 : po[k]});
            else m_ovf[c] = 1'b1;
          end
        end
      end
    end
    tn.v = gv; tn.w = gw; tn.c = gc;
    tq.push_back(tn);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [NK-1:0][W-1:0] po, input logic [NC-1:0] rdy);
    cycle('0, '0, '0, po, rdy);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    grant_valid = '0; grant_wr = '0; grant_consumer = '0;
    plm_outputs = '0; resp_ready = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({resp_valid, resp_wr, overflow, collision} !== '0) begin
      n_fail++; $display("FAIL reset_flags: got %0h expected 0", {resp_valid, resp_wr, overflow, collision});
    end
    do_reset();
    n_tests++;
    if (resp_data !== '0 || resp_valid !== '0) begin
      n_fail++; $display("FAIL reset_data: got v=%0h d=%0h expected 0", resp_valid, resp_data);
    end
  endtask

  task automatic test_single_read;
    do_reset();
    cycle(2'b01, 2'b00, {2'd0, 2'd1}, '0, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b000) begin n_fail++; $display("FAIL read_early1: got %b expected 000", resp_valid); end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b000) begin n_fail++; $display("FAIL read_early2: got %b expected 000", resp_valid); end
    idle({8'h00, 8'hA5}, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b010 || resp_data[1] !== 8'hA5 || resp_wr[1] !== 1'b0) begin
      n_fail++; $display("FAIL read_resp: got v=%b d=%0h wr=%b expected v=010 d=a5 wr=0", resp_valid, resp_data[1], resp_wr[1]);
    end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b000) begin n_fail++; $display("FAIL read_once: got %b expected 000", resp_valid); end
  endtask

  task automatic test_write_ack;
    do_reset();
    cycle(2'b01, 2'b01, '0, {8'hFF, 8'hFF}, 3'b111);
    idle({8'hFF, 8'hFF}, 3'b111);
    idle({8'hFF, 8'hFF}, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b001 || resp_wr[0] !== 1'b1 || resp_data[0] !== 8'h00) begin
      n_fail++; $display("FAIL write_ack: got v=%b wr=%b d=%0h expected v=001 wr=1 d=0", resp_valid, resp_wr[0], resp_data[0]);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    cycle(2'b01, 2'b00, '0, '0, 3'b110);
    cycle(2'b01, 2'b00, '0, '0, 3'b110);
    cycle(2'b01, 2'b00, '0, {8'h00, 8'h01}, 3'b110);
    idle({8'h00, 8'h02}, 3'b110);
    n_tests++;
    if (overflow !== 3'b000) begin n_fail++; $display("FAIL ovf_early: got %b expected 000", overflow); end
    idle({8'h00, 8'h03}, 3'b110);
    n_tests++;
    if (resp_valid[0] !== 1'b1 || resp_data[0] !== 8'h01 || overflow !== 3'b001) begin
      n_fail++; $display("FAIL ovf_set: got v=%b d=%0h ovf=%b expected v=1 d=1 ovf=001", resp_valid[0], resp_data[0], overflow);
    end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid[0] !== 1'b1 || resp_data[0] !== 8'h02) begin
      n_fail++; $display("FAIL ovf_second: got v=%b d=%0h expected v=1 d=2", resp_valid[0], resp_data[0]);
    end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid[0] !== 1'b0 || overflow[0] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain: got v=%b ovf=%b expected v=0 ovf=1", resp_valid[0], overflow[0]);
    end
  endtask

  task automatic test_full_pop;
    do_reset();
    cycle(2'b01, 2'b00, '0, '0, 3'b110);
    cycle(2'b01, 2'b00, '0, '0, 3'b110);
    cycle(2'b01, 2'b00, '0, {8'h00, 8'h01}, 3'b110);
    idle({8'h00, 8'h02}, 3'b110);
    n_tests++;
    if (resp_valid[0] !== 1'b1 || resp_data[0] !== 8'h01) begin
      n_fail++; $display("FAIL full_head: got v=%b d=%0h expected v=1 d=1", resp_valid[0], resp_data[0]);
    end
    idle({8'h00, 8'h03}, 3'b111);
    n_tests++;
    if (resp_data[0] !== 8'h02 || overflow !== 3'b000) begin
      n_fail++; $display("FAIL full_pop_push: got d=%0h ovf=%b expected d=2 ovf=000", resp_data[0], overflow);
    end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid[0] !== 1'b1 || resp_data[0] !== 8'h03) begin
      n_fail++; $display("FAIL full_third: got v=%b d=%0h expected v=1 d=3", resp_valid[0], resp_data[0]);
    end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid[0] !== 1'b0 || overflow !== 3'b000) begin
      n_fail++; $display("FAIL full_drain: got v=%b ovf=%b expected v=0 ovf=000", resp_valid[0], overflow);
    end
  endtask

  task automatic test_collision;
    do_reset();
    cycle(2'b11, 2'b00, {2'd0, 2'd0}, '0, 3'b111);
    idle('0, 3'b111);
    n_tests++;
    if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_early: got %b expected 0", collision); end
    idle({8'h22, 8'h11}, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b001 || resp_data[0] !== 8'h11 || collision !== 1'b1) begin
      n_fail++; $display("FAIL coll_win: got v=%b d=%0h coll=%b expected v=001 d=11 coll=1", resp_valid, resp_data[0], collision);
    end
    idle('0, 3'b111);
    n_tests++;
    if (resp_valid !== 3'b000 || collision !== 1'b1) begin
      n_fail++; $display("FAIL coll_sticky: got v=%b coll=%b expected v=000 coll=1", resp_valid, collision);
    end
  endtask

  task automatic test_discard;
    do_reset();
    cycle(2'b11, 2'b00, {2'd3, 2'd3}, '0, 3'b111);
    for (int i = 0; i < 4; i++) begin
      idle({8'hAA, 8'hAA}, 3'b111);
      n_tests++;
      if (resp_valid !== 3'b000 || collision !== 1'b0 || overflow !== 3'b000) begin
        n_fail++; $display("FAIL discard: got v=%b coll=%b ovf=%b expected all 0", resp_valid, collision, overflow);
      end
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    cycle(2'b01, 2'b00, {2'd0, 2'd1}, '0, 3'b111);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 5; i++) begin
      idle({8'h55, 8'h55}, 3'b111);
      n_tests++;
      if (resp_valid !== 3'b000 || collision !== 1'b0 || overflow !== 3'b000) begin
        n_fail++; $display("FAIL midflight: got v=%b coll=%b ovf=%b expected all 0", resp_valid, collision, overflow);
      end
    end
  endtask

  task automatic test_random;
    logic [W:0] h;
    logic [NK-1:0][1:0] gc;
    logic [NK-1:0][W-1:0] po;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NC; c++) begin
        n_tests++;
        if (resp_valid[c] !== (mq[c].size() > 0)) begin
          n_fail++; $display("FAIL rand_valid[%0d] cyc %0d: got %b expected %b", c, n, resp_valid[c], mq[c].size() > 0);
        end else if (mq[c].size() > 0) begin
          h = mq[c][0];
          if (resp_data[c] !== h[W-1:0] || resp_wr[c] !== h[W]) begin
            n_fail++; $display("FAIL rand_head[%0d] cyc %0d: got d=%0h wr=%b expected d=%0h wr=%b", c, n, resp_data[c], resp_wr[c], h[W-1:0], h[W]);
          end
        end
      end
      n_tests++;
      if (overflow !== m_ovf || collision !== m_coll) begin
        n_fail++; $display("FAIL rand_flags cyc %0d: got ovf=%b coll=%b expected ovf=%b coll=%b", n, overflow, collision, m_ovf, m_coll);
      end
      for (int k = 0; k < NK; k++) begin
        gc[k] = 2'($urandom_range(3, 0));
        po[k] = 8'($urandom);
      end
      cycle(NK'($urandom), NK'($urandom), gc, po, NC'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1;
    grant_valid = '0; grant_wr = '0; grant_consumer = '0;
    plm_outputs = '0; resp_ready = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_ack();
    test_overflow();
    test_full_pop();
    test_collision();
    test_discard();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
